stage_mem: RTL

//  Memory-access stage of the five-stage pipeline CPU; consumes EX-stage results over a valid/ready handshake.

---
 rtl/stage_mem.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: takes EX results over valid/ready, runs data-memory
// load/store transactions with byte-lane steering, and emits one write-back packet per op.
module stage_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_signed,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_exc
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    state_e             state_q;

    // Attributes of the op in flight, needed when the ack returns
    logic [REG_W-1:0]   op_rd_q;
    logic               op_reg_write_q;
    logic               op_load_q;
    logic [1:0]         op_size_q;
    logic               op_signed_q;
    logic [1:0]         op_off_q;

    logic               accept;
    logic               is_mem;
    logic               is_load;
    logic               misaligned;
    logic [1:0]         ex_off;
    logic [3:0]         st_be;
    logic [DATA_W-1:0]  st_wdata;
    logic [DATA_W-1:0]  ld_word;
    logic [DATA_W-1:0]  ld_data;

    assign ex_ready = (state_q == StIdle);
    assign accept   = ex_valid && ex_ready && !flush;
    assign is_mem   = ex_mem_read || ex_mem_write;
    // Read+write together is illegal and resolved as a load
    assign is_load  = ex_mem_read;
    assign ex_off   = ex_alu_result[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (ex_mem_size)
            SizeByte: misaligned = 1'b0;
            SizeHalf: misaligned = ex_off[0];
            SizeWord: misaligned = (ex_off != 2'b00);
            default:  misaligned = 1'b1;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_store_data;
        if (!is_load) begin
            case (ex_mem_size)
                SizeByte: begin
                    st_be    = 4'b0001 << ex_off;
                    st_wdata = {4{ex_store_data[7:0]}};
                end
                SizeHalf: begin
                    st_be    = ex_off[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{ex_store_data[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = ex_store_data;
                end
            endcase
        end
    end

    assign ld_word = dmem_rdata >> {op_off_q, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (op_size_q)
            SizeByte: ld_data = {{24{op_signed_q & ld_word[7]}}, ld_word[7:0]};
            SizeHalf: ld_data = {{16{op_signed_q & ld_word[15]}}, ld_word[15:0]};
            default:  ld_data = ld_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_be        <= 4'b0000;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            misalign_exc   <= 1'b0;
            op_rd_q        <= '0;
            op_reg_write_q <= 1'b0;
            op_load_q      <= 1'b0;
            op_size_q      <= 2'b00;
            op_signed_q    <= 1'b0;
            op_off_q       <= 2'b00;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= ex_reg_write;
                            wb_rd        <= ex_rd;
                            wb_data      <= ex_alu_result;
                        end else if (misaligned) begin
                            misalign_exc <= 1'b1;
                            wb_valid     <= 1'b1;
                            wb_reg_write <= 1'b0;
                            wb_rd        <= ex_rd;
                        end else begin
                            state_q        <= StAccess;
                            dmem_req       <= 1'b1;
                            dmem_we        <= !is_load;
                            dmem_addr      <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            dmem_wdata     <= st_wdata;
                            dmem_be        <= st_be;
                            op_rd_q        <= ex_rd;
                            op_reg_write_q <= ex_reg_write;
                            op_load_q      <= is_load;
                            op_size_q      <= ex_mem_size;
                            op_signed_q    <= ex_mem_signed;
                            op_off_q       <= ex_off;
                        end
                    end
                end
                StAccess: begin
                    // Flush is deliberately ignored: an issued access must complete
                    if (dmem_ack) begin
                        state_q      <= StIdle;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= op_rd_q;
                        wb_reg_write <= op_load_q && op_reg_write_q;
                        if (op_load_q) begin
                            wb_data <= ld_data;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
